// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, receiver FSM states
// and the bit layout of one receive-FIFO entry.
package uart_pkg;

   localparam logic [1:0] PAR_SPACE = 2'b00;
   localparam logic [1:0] PAR_EVEN  = 2'b01;
   localparam logic [1:0] PAR_ODD   = 2'b10;
   localparam logic [1:0] PAR_MARK  = 2'b11;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4,
      BREAK_WAIT = 3'd5
   } rx_state_e;

   localparam int unsigned ENTRY_DATA_LSB = 0;
   localparam int unsigned ENTRY_DATA_W   = 8;
   localparam int unsigned ENTRY_PE_BIT   = 8;
   localparam int unsigned ENTRY_FE_BIT   = 9;
   localparam int unsigned ENTRY_BRK_BIT  = 10;
   localparam int unsigned ENTRY_W        = 11;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO for received frames; a push while full is accepted only if a
// pop happens in the same cycle.
module uart_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     valid_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             empty, do_push, do_pop;

   always_comb begin
      empty    = (count_q == '0);
      full_o   = (count_q == (AW+1)'(DEPTH));
      do_pop   = pop_i & ~empty;
      do_push  = push_i & (~full_o | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the output is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_comb begin
      valid_o   = ~empty;
      rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
      count_o   = count_q;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote bit sampling, parity/framing/break
// detection and a show-ahead receive FIFO with sticky overflow.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned DIV_WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   input  logic [1:0]               dataBits,
   input  logic                     hasParity,
   input  logic [1:0]               parityMode,
   input  logic                     extraStopBit,
   input  logic [DIV_WIDTH-1:0]     clockDivisor,
   output logic [7:0]               rdData,
   output logic                     rdParityError,
   output logic                     rdFramingError,
   output logic                     rdBreak,
   output logic                     rdValid,
   input  logic                     rdReq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clearOverflow
);

   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   logic [1:0]           hist_q;
   rx_state_e            state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
   logic [2:0]           bits_m1_q, bits_m1_d, bit_idx_q, bit_idx_d;
   logic                 has_par_q, has_par_d, two_stop_q, two_stop_d;
   logic [1:0]           par_mode_q, par_mode_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [7:0]           data_q, data_d;
   logic                 ones_q, ones_d, all_zero_q, all_zero_d;
   logic                 pe_q, pe_d, fe_q, fe_d;
   logic                 push_q, push_d;
   logic [ENTRY_W-1:0]   entry_q, entry_d;
   logic                 overflow_q, overflow_d;
   logic                 start_edge, sample, vote, brk;
   logic                 fifo_full, fifo_pop;
   logic [ENTRY_W-1:0]   fifo_rd;

   always_comb begin
      div_eff    = (clockDivisor < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : clockDivisor;
      start_edge = rx_prev_q & ~rx_sync_q;
      sample     = (cnt_q == '0);
      vote       = maj3(hist_q[1], hist_q[0], rx_sync_q);
      brk        = 1'b0;

      state_d    = state_q;
      cnt_d      = sample ? div_q - DIV_WIDTH'(1) : cnt_q - DIV_WIDTH'(1);
      div_d      = div_q;
      bits_m1_d  = bits_m1_q;
      has_par_d  = has_par_q;
      par_mode_d = par_mode_q;
      two_stop_d = two_stop_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      data_d     = data_q;
      ones_d     = ones_q;
      all_zero_d = all_zero_q;
      pe_d       = pe_q;
      fe_d       = fe_q;
      push_d     = 1'b0;
      entry_d    = entry_q;

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d    = START;
               div_d      = div_eff;
               // Counter reaches zero exactly floor(D/2) cycles after the edge.
               cnt_d      = (div_eff >> 1) - DIV_WIDTH'(1);
               bits_m1_d  = {1'b0, dataBits} + 3'd4;
               has_par_d  = hasParity;
               par_mode_d = parityMode;
               two_stop_d = extraStopBit;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               data_d     = '0;
               ones_d     = 1'b0;
               all_zero_d = 1'b1;
               pe_d       = 1'b0;
               fe_d       = 1'b0;
            end
         end
         START: begin
            if (sample) begin
               state_d = vote ? IDLE : DATA;
            end
         end
         DATA: begin
            if (sample) begin
               data_d[bit_idx_q] = vote;
               ones_d     = ones_q ^ vote;
               all_zero_d = all_zero_q & ~vote;
               if (bit_idx_q == bits_m1_q) begin
                  state_d = has_par_q ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (sample) begin
               all_zero_d = all_zero_q & ~vote;
               case (par_mode_q)
                  PAR_EVEN:  pe_d = ones_q ^ vote;
                  PAR_ODD:   pe_d = ~(ones_q ^ vote);
                  PAR_SPACE: pe_d = vote;
                  default:   pe_d = ~vote;
               endcase
               state_d = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               fe_d       = fe_q | ~vote;
               all_zero_d = all_zero_q & ~vote;
               if (stop_idx_q == two_stop_q) begin
                  brk     = all_zero_q & ~vote;
                  push_d  = 1'b1;
                  entry_d = '0;
                  if (brk) begin
                     entry_d[ENTRY_BRK_BIT] = 1'b1;
                     state_d = BREAK_WAIT;
                  end else begin
                     entry_d[ENTRY_DATA_LSB +: ENTRY_DATA_W] = data_q;
                     entry_d[ENTRY_PE_BIT] = pe_q;
                     entry_d[ENTRY_FE_BIT] = fe_q | ~vote;
                     state_d = IDLE;
                  end
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         BREAK_WAIT: begin
            if (rx_sync_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_pop   = rdReq & rdValid;
      overflow_d = (overflow_q & ~clearOverflow) | (push_q & fifo_full & ~fifo_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         hist_q     <= 2'b11;
         state_q    <= IDLE;
         cnt_q      <= '0;
         div_q      <= DIV_WIDTH'(4);
         bits_m1_q  <= '0;
         has_par_q  <= 1'b0;
         par_mode_q <= PAR_SPACE;
         two_stop_q <= 1'b0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         data_q     <= '0;
         ones_q     <= 1'b0;
         all_zero_q <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         push_q     <= 1'b0;
         entry_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         hist_q     <= {hist_q[0], rx_sync_q};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bits_m1_q  <= bits_m1_d;
         has_par_q  <= has_par_d;
         par_mode_q <= par_mode_d;
         two_stop_q <= two_stop_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         data_q     <= data_d;
         ones_q     <= ones_d;
         all_zero_q <= all_zero_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
         push_q     <= push_d;
         entry_q    <= entry_d;
         overflow_q <= overflow_d;
      end
   end

   uart_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_q),
      .push_data_i (entry_q),
      .pop_i       (fifo_pop),
      .rd_data_o   (fifo_rd),
      .valid_o     (rdValid),
      .full_o      (fifo_full),
      .count_o     (count)
   );

   always_comb begin
      rdData         = fifo_rd[ENTRY_DATA_LSB +: ENTRY_DATA_W];
      rdParityError  = fifo_rd[ENTRY_PE_BIT];
      rdFramingError = fifo_rd[ENTRY_FE_BIT];
      rdBreak        = fifo_rd[ENTRY_BRK_BIT];
      overflow       = overflow_q;
   end

endmodule
